// File: rtl/game_pkg.sv
// Shared game definitions: sequencer states, keyboard codes and campaign length.
// Imported by the state controller, roam and the battle engine.
package game_pkg;

  typedef enum logic [2:0] {
    TITLE     = 3'd0,
    FADE_ROAM = 3'd1,
    ROAM      = 3'd2,
    FADE_BAT  = 3'd3,
    BATTLE    = 3'd4,
    GAME_OVER = 3'd5,
    CHAMPION  = 3'd6
  } game_state_t;

  // USB HID usage codes
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;

  localparam int NUM_BATTLES_DEF = 5;

endpackage

// File: rtl/edge_pulse.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Emits a registered one-cycle pulse per rising edge of an asynchronous level.
module edge_pulse (
  input  logic Clk,
  input  logic Reset_n,
  input  logic din,
  output logic pulse
);

  logic sync0_r;
  logic sync1_r;
  logic prev_r;
  logic pulse_r;

  // synchronize the level and register the rising-edge pulse
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync0_r <= 1'b0;
      sync1_r <= 1'b0;
      prev_r  <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      sync0_r <= din;
      sync1_r <= sync0_r;
      prev_r  <= sync1_r;
      pulse_r <= sync1_r & ~prev_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/game_state_ctrl.sv
// Top-level game sequencer: title -> roam -> battle ... -> champion / game over,
// with frame-counted fades between screens. Outputs are registered state decodes.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int         NUM_BATTLES = NUM_BATTLES_DEF,
  parameter int         FADE_FRAMES = 30,
  parameter logic [7:0] KEY_ENTER   = game_pkg::KEY_ENTER
) (
  input  logic                               Clk,
  input  logic                               Reset_n,
  input  logic                               frame_clk,
  input  logic [7:0]                         keycode,
  input  logic                               start_battle,
  input  logic                               new_room,
  input  logic                               battle_won,
  input  logic                               battle_lost,
  output logic                               is_start,
  output logic                               is_roam,
  output logic                               is_battle,
  output logic                               is_fade,
  output logic [$clog2(FADE_FRAMES+1)-1:0]   fade_cnt,
  output logic [2:0]                         cur_battle,
  output logic                               game_over,
  output logic                               champion
);

  localparam int FW = $clog2(FADE_FRAMES + 1);

  localparam logic [2:0] ST_TITLE     = 3'(TITLE);
  localparam logic [2:0] ST_FADE_ROAM = 3'(FADE_ROAM);
  localparam logic [2:0] ST_ROAM      = 3'(ROAM);
  localparam logic [2:0] ST_FADE_BAT  = 3'(FADE_BAT);
  localparam logic [2:0] ST_BATTLE    = 3'(BATTLE);
  localparam logic [2:0] ST_GAME_OVER = 3'(GAME_OVER);
  localparam logic [2:0] ST_CHAMPION  = 3'(CHAMPION);

  localparam logic [FW-1:0] FADE_LOAD   = FW'(FADE_FRAMES);
  localparam logic [2:0]    LAST_BATTLE = 3'(NUM_BATTLES - 1);

  logic [2:0]    state_r;
  logic [2:0]    state_nxt_s;
  logic [FW-1:0] fade_cnt_r;
  logic [FW-1:0] fade_cnt_nxt_s;
  logic [2:0]    cur_battle_r;
  logic [2:0]    cur_battle_nxt_s;
  logic [7:0]    key_prev_r;
  logic          tick_s;
  logic          enter_evt_s;
  logic          fade_done_s;
  logic          is_start_r;
  logic          is_roam_r;
  logic          is_battle_r;
  logic          is_fade_r;
  logic          game_over_r;
  logic          champion_r;

  edge_pulse u_frame_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .din     (frame_clk),
    .pulse   (tick_s)
  );

  assign enter_evt_s = (keycode == KEY_ENTER) && (key_prev_r != KEY_ENTER);
  // a zero count also ends the fade so the counter can never underflow
  assign fade_done_s = tick_s && (fade_cnt_r <= FW'(1));

  // next-state, fade counter and elite index
  always_comb begin
    state_nxt_s      = state_r;
    fade_cnt_nxt_s   = fade_cnt_r;
    cur_battle_nxt_s = cur_battle_r;
    case (state_r)
      ST_TITLE: begin
        if (enter_evt_s) begin
          state_nxt_s    = ST_FADE_ROAM;
          fade_cnt_nxt_s = FADE_LOAD;
        end else begin
          state_nxt_s = ST_TITLE;
        end
      end
      ST_FADE_ROAM, ST_FADE_BAT: begin
        if (fade_done_s) begin
          state_nxt_s    = (state_r == ST_FADE_ROAM) ? ST_ROAM : ST_BATTLE;
          fade_cnt_nxt_s = '0;
        end else if (tick_s) begin
          fade_cnt_nxt_s = fade_cnt_r - FW'(1);
        end else begin
          fade_cnt_nxt_s = fade_cnt_r;
        end
      end
      ST_ROAM: begin
        if (start_battle) begin
          state_nxt_s    = ST_FADE_BAT;
          fade_cnt_nxt_s = FADE_LOAD;
        end else if (new_room && (cur_battle_r >= LAST_BATTLE)) begin
          state_nxt_s = ST_CHAMPION;
        end else if (new_room) begin
          cur_battle_nxt_s = cur_battle_r + 3'd1;
        end else begin
          state_nxt_s = ST_ROAM;
        end
      end
      ST_BATTLE: begin
        if (battle_lost) begin
          state_nxt_s = ST_GAME_OVER;
        end else if (battle_won) begin
          state_nxt_s = ST_ROAM;
        end else begin
          state_nxt_s = ST_BATTLE;
        end
      end
      ST_GAME_OVER, ST_CHAMPION: begin
        if (enter_evt_s) begin
          state_nxt_s      = ST_TITLE;
          cur_battle_nxt_s = 3'd0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s      = ST_TITLE;
        fade_cnt_nxt_s   = '0;
        cur_battle_nxt_s = 3'd0;
      end
    endcase
  end

  // state, counters and flags; flags decode the next state so they track state_r exactly
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r      <= ST_TITLE;
      fade_cnt_r   <= '0;
      cur_battle_r <= 3'd0;
      key_prev_r   <= 8'h00;
      is_start_r   <= 1'b1;
      is_roam_r    <= 1'b0;
      is_battle_r  <= 1'b0;
      is_fade_r    <= 1'b0;
      game_over_r  <= 1'b0;
      champion_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      fade_cnt_r   <= fade_cnt_nxt_s;
      cur_battle_r <= cur_battle_nxt_s;
      key_prev_r   <= keycode;
      is_start_r   <= (state_nxt_s == ST_TITLE);
      is_roam_r    <= (state_nxt_s == ST_ROAM);
      is_battle_r  <= (state_nxt_s == ST_BATTLE);
      is_fade_r    <= (state_nxt_s == ST_FADE_ROAM) || (state_nxt_s == ST_FADE_BAT);
      game_over_r  <= (state_nxt_s == ST_GAME_OVER);
      champion_r   <= (state_nxt_s == ST_CHAMPION);
    end
  end

  assign is_start   = is_start_r;
  assign is_roam    = is_roam_r;
  assign is_battle  = is_battle_r;
  assign is_fade    = is_fade_r;
  assign fade_cnt   = fade_cnt_r;
  assign cur_battle = cur_battle_r;
  assign game_over  = game_over_r;
  assign champion   = champion_r;

endmodule
